// File: rtl/btod_sequencer_pkg.sv
// Shared types for the btod sequencer: command/payload layouts, FSM states and defaults.
package btod_seq_package;

    localparam int BTOD_ADDR_W          = 16;
    localparam int BTOD_LEN_W           = 8;
    localparam int BTOD_FIFO_DEPTH      = 4;
    localparam int BTOD_TIMEOUT_DEFAULT = 1023;

    typedef struct packed {
        logic [BTOD_ADDR_W-1:0] addr;
        logic [BTOD_LEN_W-1:0]  idx;
    } btodPayloadSt;

    typedef struct packed {
        logic [BTOD_ADDR_W-1:0] base;
        logic [BTOD_LEN_W-1:0]  len;
    } btodCmdSt;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NOTIFY,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } btod_state_e;

endpackage

// File: rtl/btod_sequencer_if.sv
// Command, startDone, btod, dup mirror and status signals of the sequencer.
// master = sequencer side, slave = command source / blockB / control plane side.
interface btod_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
);
    logic                    cmd_vld;
    logic                    cmd_rdy;
    logic [ADDR_W-1:0]       cmd_base;
    logic [LEN_W-1:0]        cmd_len;
    logic                    start_notify;
    logic                    start_ack;
    logic                    btod_req;
    logic [ADDR_W+LEN_W-1:0] btod_data;
    logic                    btod_ack;
    logic                    dup_vld;
    logic                    dup_rdy;
    logic [ADDR_W+LEN_W-1:0] dup_data;
    logic                    done_pulse;
    logic                    err_timeout;
    logic [LEN_W-1:0]        beat_cnt;

    modport master (
        input  cmd_vld, cmd_base, cmd_len, start_ack, btod_ack, dup_rdy,
        output cmd_rdy, start_notify, btod_req, btod_data, dup_vld, dup_data,
               done_pulse, err_timeout, beat_cnt
    );

    modport slave (
        output cmd_vld, cmd_base, cmd_len, start_ack, btod_ack, dup_rdy,
        input  cmd_rdy, start_notify, btod_req, btod_data, dup_vld, dup_data,
               done_pulse, err_timeout, beat_cnt
    );
endinterface

// File: rtl/btod_sequencer_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap naturally because DEPTH is a power of two.
module btod_cmd_fifo
    import btod_seq_package::*;
#(
    parameter type T     = btodCmdSt,
    parameter int  DEPTH = BTOD_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     rd_data,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Push is refused when full even if a pop happens in the same cycle.
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/btod_sequencer.sv
// Pops burst commands, runs the startDone handshake, then issues one btod req/ack beat
// at a time while mirroring each beat onto the dup stream.
module btod_sequencer
    import btod_seq_package::*;
#(
    parameter int ADDR_W     = BTOD_ADDR_W,
    parameter int LEN_W      = BTOD_LEN_W,
    parameter int FIFO_DEPTH = BTOD_FIFO_DEPTH,
    parameter int TIMEOUT    = BTOD_TIMEOUT_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    btod_sequencer_if.master bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  idx;
    } payload_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    cmd_t        fifo_wr, fifo_rd;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;

    btod_state_e      state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    payload_t         payload_q, payload_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [15:0]      tmo_cnt_q, tmo_cnt_d;
    logic             btod_req_q, btod_req_d;
    logic             dup_vld_q, dup_vld_d;
    logic             err_q, err_d;
    logic             btod_done, dup_done;
    logic [LEN_W-1:0] beat_inc;

    assign fifo_wr   = '{base: bus.cmd_base, len: bus.cmd_len};
    assign fifo_push = bus.cmd_vld && !fifo_full;

    btod_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        payload_d  = payload_q;
        beat_cnt_d = beat_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        btod_req_d = btod_req_q;
        dup_vld_d  = dup_vld_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;
        // A side counts as done if already retired or retiring this cycle.
        btod_done  = !btod_req_q || bus.btod_ack;
        dup_done   = !dup_vld_q || bus.dup_rdy;
        beat_inc   = beat_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cmd_d      = fifo_rd;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = ST_NOTIFY;
                end
            end
            ST_NOTIFY: begin
                if (bus.start_ack) begin
                    state_d = (cmd_q.len != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                payload_d.addr = cmd_q.base + ADDR_W'(beat_cnt_q);
                payload_d.idx  = beat_cnt_q;
                btod_req_d     = 1'b1;
                dup_vld_d      = 1'b1;
                tmo_cnt_d      = '0;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.btod_ack) btod_req_d = 1'b0;
                if (bus.dup_rdy)  dup_vld_d  = 1'b0;
                if (btod_done && dup_done) begin
                    state_d = ST_NEXT;
                end else if (btod_req_q && !bus.btod_ack) begin
                    // Only a missing btod ack can time out; a same-cycle ack wins above.
                    if (tmo_cnt_q + 16'd1 == TMO_LIMIT) begin
                        err_d      = 1'b1;
                        btod_req_d = 1'b0;
                        dup_vld_d  = 1'b0;
                        state_d    = ST_DONE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end
            end
            ST_NEXT: begin
                beat_cnt_d = beat_inc;
                state_d    = (beat_inc == cmd_q.len) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            payload_q  <= '0;
            beat_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            btod_req_q <= 1'b0;
            dup_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            payload_q  <= payload_d;
            beat_cnt_q <= beat_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            btod_req_q <= btod_req_d;
            dup_vld_q  <= dup_vld_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_rdy      = !fifo_full;
    assign bus.start_notify = (state_q == ST_NOTIFY);
    assign bus.btod_req     = btod_req_q;
    assign bus.btod_data    = payload_q;
    assign bus.dup_vld      = dup_vld_q;
    assign bus.dup_data     = payload_q;
    assign bus.done_pulse   = (state_q == ST_DONE);
    assign bus.err_timeout  = err_q;
    assign bus.beat_cnt     = beat_cnt_q;
endmodule

// File: tb/tb_btod_sequencer.sv
// Scoreboard bench: expected beats/completions are queued with each command and a
// negedge monitor pops and compares them as the sequencer presents handshakes.
module tb_btod_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btod_sequencer_if #(.ADDR_W(16), .LEN_W(8)) bus ();

    btod_sequencer #(
        .ADDR_W     (16),
        .LEN_W      (8),
        .FIFO_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [23:0] bq[$];
    logic [23:0] dq[$];
    logic [8:0]  doneq[$];
    int          btod_hs = 0, dup_hs = 0, done_cnt = 0, notify_cnt = 0;
    int          req_run = 0, last_run = 0;
    logic        notify_prev = 1'b0;
    bit          btod_en = 1'b1, dup_en = 1'b1, sack_en = 1'b1;
    int          btod_lat = 0, dup_lat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    task automatic expect_cmd(input logic [15:0] b, input logic [7:0] l);
        for (int i = 0; i < int'(l); i++) begin
            logic [15:0] a;
            a = b + 16'(i);
            bq.push_back({a, 8'(i)});
            dq.push_back({a, 8'(i)});
        end
        doneq.push_back({1'b0, l});
    endtask

    task automatic push_cmd(input logic [15:0] b, input logic [7:0] l);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_vld  = 1'b1;
        bus.cmd_base = b;
        bus.cmd_len  = l;
        while (!bus.cmd_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_rdy) flag("push_timeout", 32'(b));
        @(posedge clk);
        #1;
        bus.cmd_vld = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) flag("done_wait_expired", 32'(done_cnt));
    endtask

    // Responder: decides acks shortly after each edge from the current request levels.
    initial begin
        int bk;
        int dk;
        bk = 0;
        dk = 0;
        bus.btod_ack  = 1'b0;
        bus.dup_rdy   = 1'b0;
        bus.start_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.btod_req) begin
                bus.btod_ack = btod_en && (bk >= btod_lat);
                bk++;
            end else begin
                bus.btod_ack = 1'b0;
                bk = 0;
            end
            if (bus.dup_vld) begin
                bus.dup_rdy = dup_en && (dk >= dup_lat);
                dk++;
            end else begin
                bus.dup_rdy = 1'b0;
                dk = 0;
            end
            bus.start_ack = bus.start_notify && sack_en;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.btod_req) begin
                req_run++;
                if (bq.size() == 0) flag("btod_unexpected", 32'(bus.btod_data));
                else begin
                    chk("btod_data", 32'(bus.btod_data), 32'(bq[0]));
                    if (bus.btod_ack) begin
                        chk("beat_order", 32'((dup_hs - btod_hs) inside {0, 1}), 32'd1);
                        void'(bq.pop_front());
                        btod_hs++;
                    end
                end
            end else if (req_run != 0) begin
                last_run = req_run;
                req_run  = 0;
            end
            if (bus.dup_vld) begin
                if (dq.size() == 0) flag("dup_unexpected", 32'(bus.dup_data));
                else begin
                    chk("dup_data", 32'(bus.dup_data), 32'(dq[0]));
                    if (bus.dup_rdy) begin
                        void'(dq.pop_front());
                        dup_hs++;
                    end
                end
            end
            if (bus.done_pulse) begin
                done_cnt++;
                if (doneq.size() == 0) flag("done_unexpected", 32'(bus.beat_cnt));
                else chk("done_status", 32'({bus.err_timeout, bus.beat_cnt}), 32'(doneq.pop_front()));
            end
            if (bus.start_notify && !notify_prev) notify_cnt++;
            notify_prev = bus.start_notify;
        end else begin
            req_run     = 0;
            notify_prev = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.cmd_vld  = 1'b0;
        bus.cmd_base = '0;
        bus.cmd_len  = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy_in_reset", 32'(bus.cmd_rdy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("rst_outputs", 32'({bus.start_notify, bus.btod_req, bus.dup_vld,
                                bus.done_pulse, bus.err_timeout}), 32'd0);
        chk("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("rst_data", 32'({bus.btod_data, bus.dup_data}), 32'd0);

        // Basic burst with immediate responses
        expect_cmd(16'h0010, 8'd3);
        push_cmd(16'h0010, 8'd3);
        wait_done(1);
        repeat (2) @(negedge clk);
        chk("basic_notify_cnt", 32'(notify_cnt), 32'd1);
        chk("basic_beat_cnt", 32'(bus.beat_cnt), 32'd3);

        // Skewed responses in both orders
        btod_lat = 1; dup_lat = 5;
        expect_cmd(16'h0100, 8'd2);
        push_cmd(16'h0100, 8'd2);
        wait_done(2);
        btod_lat = 5; dup_lat = 1;
        expect_cmd(16'h0120, 8'd2);
        push_cmd(16'h0120, 8'd2);
        wait_done(3);
        btod_lat = 0; dup_lat = 0;
        repeat (2) @(negedge clk);
        chk("skew_btod_hs", 32'(btod_hs), 32'd7);
        chk("skew_dup_hs", 32'(dup_hs), 32'd7);

        // Address wrap and zero-length command
        expect_cmd(16'hFFFF, 8'd2);
        push_cmd(16'hFFFF, 8'd2);
        wait_done(4);
        expect_cmd(16'h0055, 8'd0);
        push_cmd(16'h0055, 8'd0);
        wait_done(5);
        repeat (5) @(negedge clk);
        chk("len0_notify_cnt", 32'(notify_cnt), 32'd5);
        chk("len0_btod_hs", 32'(btod_hs), 32'd9);

        // Ack timeout
        btod_en = 1'b0;
        bq.push_back({16'h0200, 8'h00});
        dq.push_back({16'h0200, 8'h00});
        doneq.push_back({1'b1, 8'd0});
        push_cmd(16'h0200, 8'd2);
        wait_done(6);
        repeat (3) @(negedge clk);
        chk("tmo_err", 32'(bus.err_timeout), 32'd1);
        chk("tmo_req_cycles", 32'(last_run), 32'd8);
        chk("tmo_beat_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("tmo_req_dropped", 32'(bus.btod_req), 32'd0);
        bq.delete();
        btod_en = 1'b1;
        expect_cmd(16'h0300, 8'd1);
        push_cmd(16'h0300, 8'd1);
        chk("tmo_err_sticky", 32'(bus.err_timeout), 32'd1);
        n = 0;
        while (!bus.start_notify && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_err_cleared", 32'(bus.err_timeout), 32'd0);
        wait_done(7);

        // FIFO fill while startDone is withheld
        sack_en = 1'b0;
        for (int i = 0; i < 5; i++) expect_cmd(16'h0500 + 16'(i * 16), 8'd1);
        push_cmd(16'h0500, 8'd1);
        repeat (3) @(negedge clk);
        for (int i = 1; i < 5; i++) push_cmd(16'h0500 + 16'(i * 16), 8'd1);
        @(negedge clk);
        chk("full_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        bus.cmd_vld  = 1'b1;
        bus.cmd_base = 16'h05F0;
        bus.cmd_len  = 8'd1;
        repeat (3) @(negedge clk);
        bus.cmd_vld = 1'b0;
        chk("full_still_blocked", 32'(bus.cmd_rdy), 32'd0);
        chk("full_notify_cnt", 32'(notify_cnt), 32'd8);
        sack_en = 1'b1;
        wait_done(12);
        repeat (20) @(negedge clk);
        chk("full_cmd_rdy_back", 32'(bus.cmd_rdy), 32'd1);
        chk("full_done_cnt", 32'(done_cnt), 32'd12);
        chk("full_notify_final", 32'(notify_cnt), 32'd12);

        // Reset in the middle of WAIT
        btod_en = 1'b0;
        dup_en  = 1'b0;
        bq.push_back({16'h0600, 8'h00});
        dq.push_back({16'h0600, 8'h00});
        push_cmd(16'h0600, 8'd1);
        n = 0;
        while (!bus.btod_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_req_seen", 32'(bus.btod_req), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", 32'({bus.btod_req, bus.dup_vld, bus.start_notify, bus.done_pulse}), 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_no_done", 32'(bus.done_pulse), 32'd0);
        rst = 1'b0;
        bq.delete();
        dq.delete();
        btod_en = 1'b1;
        dup_en  = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("midrst_idle", 32'({bus.btod_req, bus.dup_vld, bus.start_notify, bus.beat_cnt}), 32'd0);
        chk("midrst_done_cnt", 32'(done_cnt), 32'd12);
        chk("queues_empty", 32'(bq.size() + dq.size() + doneq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
